// File: rtl/multu_seq_pkg.sv
// Shared arithmetic definitions for the sequential multiplier.
// Holds the FSM state encoding, the default operand width and the
// MULT/MULTU select values that the instruction decoder also drives.
package multu_seq_pkg;

  // 2-bit state encoding for the multiplier FSM.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } mul_state_e;

  localparam int unsigned DefaultWidth = 32;

  // Value of signed_op for each instruction flavour.
  localparam logic OpMultu = 1'b0;
  localparam logic OpMult  = 1'b1;

endpackage

// File: rtl/multu_seq_cond_negate.sv
// Conditional two's-complement negation.
// Ports:
//   x_i   - input value
//   neg_i - 1: output ~x_i + 1, 0: pass x_i through
//   y_o   - result, same width as x_i
module multu_seq_cond_negate #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] x_i,
  input  logic             neg_i,
  output logic [Width-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + Width'(1)) : x_i;

endmodule

// File: rtl/multu_seq.sv
// Sequential radix-2 shift-add multiplier for MULT/MULTU.
// Operands are reduced to magnitudes at start, multiplied unsigned one bit per
// cycle, and the sign is applied to the full product in the final state.
// State updates on the falling edge of clock; reset is synchronous, active high.
// Ports:
//   clock, reset          - clock (falling edge active) and synchronous reset
//   start                 - begin a multiply; only honoured while idle
//   signed_op             - 1 = MULT (two's complement), 0 = MULTU
//   multiplicand/multiplier - operands, sampled on the start edge only
//   hi, lo                - registered upper/lower halves of the product
//   busy                  - operation in progress
//   done                  - one-cycle pulse when hi/lo have just been written
module multu_seq
  import multu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  mul_state_e state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             is_signed;
  logic             a_msb, b_msb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;

  assign is_signed = (signed_op == OpMult);
  assign a_msb     = multiplicand[WIDTH-1];
  assign b_msb     = multiplier[WIDTH-1];

  // |x| of the most negative value wraps back to itself, which is the correct
  // unsigned magnitude, so no special case is needed.
  multu_seq_cond_negate #(
    .Width(WIDTH)
  ) u_abs_a (
    .x_i  (multiplicand),
    .neg_i(is_signed & a_msb),
    .y_o  (abs_a)
  );

  multu_seq_cond_negate #(
    .Width(WIDTH)
  ) u_abs_b (
    .x_i  (multiplier),
    .neg_i(is_signed & b_msb),
    .y_o  (abs_b)
  );

  multu_seq_cond_negate #(
    .Width(2 * WIDTH)
  ) u_prod_neg (
    .x_i  ({acc_q, mag_b_q}),
    .neg_i(neg_q),
    .y_o  (prod)
  );

  // One extra bit so the adder carry lands in acc on the shift.
  assign sum = {1'b0, acc_q} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    acc_d   = acc_q;
    count_d = count_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          mag_a_d = abs_a;
          mag_b_d = abs_b;
          acc_d   = '0;
          count_d = '0;
          // Zero operands force a positive result so no sign is applied.
          neg_d   = is_signed & (a_msb ^ b_msb) & (|multiplicand) & (|multiplier);
        end
      end
      StRun: begin
        // {acc, mag_b} <= {sum, mag_b} >> 1; consumed multiplier bits fall out
        // of mag_b while product bits enter from the top.
        acc_d   = sum[WIDTH:1];
        mag_b_d = {sum[0], mag_b_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        hi_d    = prod[2*WIDTH-1:WIDTH];
        lo_d    = prod[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: directed table, hand-written corner
// sequences (ignored starts, mid-run reset) and random operands checked
// against a plain 64-bit arithmetic reference.
module tb_multu_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  multu_seq dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done)
  );

  // DUT acts on the falling edge; the bench drives and samples on the rising edge.
  always #5 clock = ~clock;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Issue one multiply from idle, wait for done, check latency, result, hold and pulse width.
  task automatic do_mul(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int busy_cycles = 0;
    int hold_err    = 0;
    bit seen        = 0;
    @(posedge clock);
    start = 1'b1; signed_op = s; multiplicand = a; multiplier = b;
    @(posedge clock);
    // Scramble inputs after the start edge; the DUT must not look at them.
    start = 1'b0; signed_op = $urandom_range(0, 1);
    multiplicand = $urandom; multiplier = $urandom;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) busy_cycles++;
        if (hi !== prev_hi || lo !== prev_lo) hold_err++;
        @(posedge clock);
      end
    end
    check({name, " done_seen"}, 64'(seen), 64'd1);
    check({name, " busy_cycles"}, 64'(busy_cycles), 64'd33);
    check({name, " busy_at_done"}, 64'(busy), 64'd0);
    check({name, " hold_during_run"}, 64'(hold_err), 64'd0);
    check({name, " result"}, {hi, lo}, {exp_hi, exp_lo});
    prev_hi = hi; prev_lo = lo;
    @(posedge clock);
    check({name, " done_pulse_end"}, 64'(done), 64'd0);
    check({name, " hold_after"}, {hi, lo}, {prev_hi, prev_lo});
  endtask

  vec_t vecs[8];

  initial begin
    int done_k;
    int done_cnt;
    bit seen;
    logic [63:0] p;
    logic [31:0] ra, rb;
    logic        rs;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{1'b0, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB};
    vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4] = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[5] = '{1'b1, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000};
    vecs[6] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 32'h242D2080};
    vecs[7] = '{1'b0, 32'd100,      32'd100,      32'h00000000, 32'd10000};

    reset = 1'b1; start = 1'b0; signed_op = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clock);
    check("reset_state", {28'b0, busy, done, 2'b0, hi, lo}, 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      do_mul($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    // Starts during RUN (edge 5) and during FIN are ignored; start right after done is taken.
    @(posedge clock);
    start = 1'b1; signed_op = 1'b0; multiplicand = 32'd6; multiplier = 32'd7;
    done_k = -1; done_cnt = 0;
    for (int k = 0; k <= 33; k++) begin
      @(posedge clock);
      start = (k == 4 || k == 32);
      if (start) begin multiplicand = 32'd9; multiplier = 32'd9; end
      if (done) begin done_cnt++; done_k = k; end
    end
    check("ign_done_count", 64'(done_cnt), 64'd1);
    check("ign_done_edge", 64'(done_k), 64'd33);
    check("ign_result", {hi, lo}, {32'd0, 32'd42});
    start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
    @(posedge clock);
    start = 1'b0;
    check("b2b_accept_busy", 64'(busy), 64'd1);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock);
      if (done) seen = 1;
    end
    check("b2b_done_seen", 64'(seen), 64'd1);
    check("b2b_result", {hi, lo}, {32'd0, 32'd81});
    prev_hi = hi; prev_lo = lo;

    // Mid-run reset aborts with no done pulse and clears hi/lo.
    @(posedge clock);
    start = 1'b1; signed_op = 1'b0; multiplicand = 32'hFFFFFFFF; multiplier = 32'hFFFFFFFF;
    for (int k = 0; k <= 9; k++) begin
      @(posedge clock);
      start = 1'b0;
      reset = (k == 9);
    end
    @(posedge clock);
    reset = 1'b0;
    check("rst_abort_state", {28'b0, busy, done, 2'b0, hi, lo}, 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      if (done || busy) done_cnt++;
    end
    check("rst_no_done", 64'(done_cnt), 64'd0);
    prev_hi = '0; prev_lo = '0;
    do_mul("after_reset", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);

    // Random operands, with the magnitude corners mixed in.
    for (int n = 0; n < 16; n++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom; rb = $urandom;
      if (n % 4 == 1) ra = 32'h80000000;
      if (n % 5 == 2) rb = 32'h00000000;
      if (n % 6 == 3) rb = 32'hFFFFFFFF;
      p = ref_mul(rs, ra, rb);
      do_mul($sformatf("rand%0d", n), rs, ra, rb, p[63:32], p[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multu_seq.md
Name: multu_seq

Overview:
Sequential radix-2 shift-add multiplier for the CPU's MULT/MULTU instructions; the multiply counterpart to the iterative divider in the arithmetic unit.
Accepts two 32-bit operands with a start pulse, iterates one bit per cycle, and delivers a 64-bit product split into hi/lo for the HI/LO registers.
A busy/done handshake lets the pipeline stall until the product is valid.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits.
CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
clock  input  1  system clock; all state updates on the falling edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a new multiply; sampled only in IDLE.
signed_op  input  1  1 = MULT (two's complement), 0 = MULTU.
multiplicand  input  WIDTH  operand A.
multiplier  input  WIDTH  operand B.
hi  output  WIDTH  upper half of product (registered).
lo  output  WIDTH  lower half of product (registered).
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when hi/lo have just been updated.

Behaviour:
- Reset (synchronous, sampled on the active edge): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and working registers cleared. A reset mid-operation aborts it, produces no done pulse, and zeroes hi/lo.
- States:
  - IDLE -> RUN on start.
  - RUN -> FIN after WIDTH iterations.
  - FIN -> IDLE unconditionally.
- IDLE + start, on edge E0:
  - Latch mag_a = |multiplicand| and mag_b = |multiplier| when signed_op=1 and the operand MSB is set; otherwise latch the raw operand.
  - neg = signed_op & (A[MSB] ^ B[MSB]).
  - acc=0, count=0, busy=1.
- RUN, once per edge, for edges E1..E_WIDTH:
  - sum = {1'b0,acc} + (mag_b[0] ? {1'b0,mag_a} : 0), computed WIDTH+1 bits wide.
  - {acc, mag_b} <= {sum, mag_b} >> 1.
  - count increments; on the edge where count==WIDTH-1, next state is FIN.
- FIN, edge E_WIDTH+1:
  - P = {acc, mag_b}; if neg, P = ~P + 1 across the full 2*WIDTH bits.
  - hi <= P[2W-1:W], lo <= P[W-1:0].
  - done=1 and busy=0 on this edge. done returns to 0 on the next edge.
- Latency: busy is high for exactly WIDTH+1 cycles, i.e. 33 for the default. Results are valid from the done edge onward.
- hi/lo hold their value until the next FIN or reset. They are never modified during RUN.
- start while busy (RUN or FIN) is ignored: no restart and no operand relatch. start is honoured again only in IDLE, so the earliest back-to-back start is the cycle after done.
- Operand inputs need to be stable only on the start edge.
- Boundaries:
  - -2^31 magnitude is 0x80000000 and must be handled unsigned, with no overflow.
  - 0 operand yields a 0 product, with neg masked so the result is not -0 garbage.
  - The carry from sum is always captured in acc via the WIDTH+1 adder.
- signed_op is latched at start; later changes have no effect.

Decomposition:
- Shared arithmetic package holds:
  - the state encoding constants IDLE/RUN/FIN (2-bit);
  - the WIDTH default (32);
  - the MULT/MULTU select constants shared with the decoder.
- One natural sub-module, cond_negate: a parameterised combinational block, output = neg ? (~x + 1) : x.
  - Instantiated at WIDTH for the operand magnitudes.
  - Instantiated at 2*WIDTH for the final product.

Test Plan:
1. MULTU 0xFFFFFFFF * 0xFFFFFFFF, start at E0 -> busy for 33 cycles; done at E33; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT -3 (0xFFFFFFFD) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Same operands with MULTU -> hi=0x00000006, lo=0xFFFFFFEB.
3. MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0. MULT 0x80000000 * 1 -> hi=0xFFFFFFFF, lo=0x80000000. MULT 0 * -5 -> hi=lo=0.
4. Start 6*7, then assert start with 9*9 at E5 and again in FIN -> both ignored; done once with lo=42, hi=0; a start the cycle after done is accepted and yields lo=81.
5. reset asserted at E10 of a run -> next edge busy=0, done=0, hi=lo=0; no done pulse follows. A fresh 2*3 then completes with lo=6 after 33 cycles.
6. Back-to-back: 0x12345678 * 0x9ABCDEF0 (MULTU), then 100*100 -> hi=0x0B00EA4E, lo=0x242D2080; then hi=0, lo=10000. hi/lo are stable between done pulses.
